// File: rtl/max_scan_ctrl_if.sv
// Bundle of the scan controller's request, ADC frame, maximum-tree and result
// signals. The controller connects through the slave modport; whatever drives
// start/frames/tree results and consumes the result uses the master modport.
interface max_scan_ctrl_if #(
  parameter int PORTS = 32
);
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  // Scan request
  logic             start;
  logic [7:0]       num_frames;

  // ADC frame handshake
  logic             frame_valid;
  logic             frame_ready;

  // Maximum tree launch and result
  logic             tree_dav;
  logic [15:0]      tree_max_value;
  logic [IDX_W-1:0] tree_max_index;
  logic             tree_max_dav;

  // Scan result and status
  logic [15:0]      res_value;
  logic [IDX_W-1:0] res_index;
  logic [7:0]       res_frame;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             timeout_err;

  modport slave (
    input  start, num_frames, frame_valid,
           tree_max_value, tree_max_index, tree_max_dav, res_ready,
    output frame_ready, tree_dav,
           res_value, res_index, res_frame, res_valid, busy, timeout_err
  );

  modport master (
    output start, num_frames, frame_valid,
           tree_max_value, tree_max_index, tree_max_dav, res_ready,
    input  frame_ready, tree_dav,
           res_value, res_index, res_frame, res_valid, busy, timeout_err
  );
endinterface

// File: rtl/max_scan_ctrl.sv
// Scan controller for an ADC maximum tree. A scan pushes num_frames frames
// through the tree one at a time (at most one frame in flight), keeps the
// largest value seen together with its channel index and frame number, and
// presents that peak with a valid/ready handshake. A tree that does not answer
// within TIMEOUT cycles ends the scan with timeout_err set and the peak so far.
module max_scan_ctrl #(
  parameter int PORTS   = 32,
  parameter int TIMEOUT = 40
) (
  input logic            clk,
  input logic            rst,
  max_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // The wait counter is loaded with 0 on the launch edge, so in the k-th cycle
  // after the launch strobe it reads k-1. Firing the timeout when it reads
  // TIMEOUT-2 makes the registered flag appear exactly TIMEOUT cycles after
  // tree_dav; a result arriving in that same cycle still wins.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_FRAME = 2'd1;
  localparam logic [1:0] S_WAIT_RES   = 2'd2;
  localparam logic [1:0] S_DONE       = 2'd3;

  logic [1:0]       state_q;
  logic [8:0]       frame_lim_q;   // frames in this scan, 1..255 (0 requested -> 1)
  logic [8:0]       frame_cnt_q;   // frames completed so far
  logic [CNT_W-1:0] wait_cnt_q;
  logic [15:0]      res_value_q;
  logic [IDX_W-1:0] res_index_q;
  logic [7:0]       res_frame_q;
  logic             timeout_err_q;

  logic launch;
  logic take_res;
  logic hit_timeout;
  logic last_frame;
  logic new_peak;

  // A frame is accepted and launched into the tree in the same cycle.
  assign launch      = (state_q == S_WAIT_FRAME) && bus.frame_valid;
  // Tree results count only while a frame is in flight.
  assign take_res    = (state_q == S_WAIT_RES) && bus.tree_max_dav;
  assign hit_timeout = (state_q == S_WAIT_RES) && !bus.tree_max_dav &&
                       (wait_cnt_q == CNT_LAST);
  assign last_frame  = (frame_cnt_q + 9'd1) == frame_lim_q;
  // The first frame always seeds the peak (even a zero); afterwards only a
  // strictly larger value replaces it, so ties keep the earlier frame.
  assign new_peak    = (frame_cnt_q == 9'd0) ||
                       (bus.tree_max_value > res_value_q);

  // Scan sequencing, peak tracking and tree timeout supervision.
  // NOTE: every register here is reset asynchronously and assigned with <=
  // only, so all of them update together from the values before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      frame_lim_q   <= 9'd0;
      frame_cnt_q   <= 9'd0;
      wait_cnt_q    <= '0;
      res_value_q   <= 16'd0;
      res_index_q   <= '0;
      res_frame_q   <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            frame_lim_q   <= (bus.num_frames == 8'd0) ? 9'd1
                                                      : {1'b0, bus.num_frames};
            frame_cnt_q   <= 9'd0;
            res_value_q   <= 16'd0;
            res_index_q   <= '0;
            res_frame_q   <= 8'd0;
            timeout_err_q <= 1'b0;
            state_q       <= S_WAIT_FRAME;
          end
        end

        S_WAIT_FRAME: begin
          if (launch) begin
            wait_cnt_q <= '0;
            state_q    <= S_WAIT_RES;
          end
        end

        S_WAIT_RES: begin
          if (take_res) begin
            if (new_peak) begin
              res_value_q <= bus.tree_max_value;
              res_index_q <= bus.tree_max_index;
              res_frame_q <= frame_cnt_q[7:0];
            end
            frame_cnt_q <= frame_cnt_q + 9'd1;
            state_q     <= last_frame ? S_DONE : S_WAIT_FRAME;
          end else if (hit_timeout) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          if (bus.res_ready) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.frame_ready = launch;
  assign bus.tree_dav    = launch;
  assign bus.res_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.res_value   = res_value_q;
  assign bus.res_index   = res_index_q;
  assign bus.res_frame   = res_frame_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Bench for max_scan_ctrl. Each scan is described as a list of frames
// (tree value, tree index, tree latency; latency 0 = tree never answers).
// The expected peak is computed from that list with a plain loop, and the
// bench plays the ADC, the maximum tree and the result consumer cycle by cycle.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_max_scan_ctrl;

  localparam int PORTS   = 32;
  localparam int TIMEOUT = 40;
  localparam int IDX_W   = $clog2(PORTS);

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  int f_val [256];
  int f_idx [256];
  int f_lat [256];

  always #5 clk = ~clk;

  max_scan_ctrl_if #(.PORTS(PORTS)) bus ();

  max_scan_ctrl #(
    .PORTS  (PORTS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},        bus.busy,        0);
    check({tag, "_res_valid"},   bus.res_valid,   0);
    check({tag, "_frame_ready"}, bus.frame_ready, 0);
    check({tag, "_tree_dav"},    bus.tree_dav,    0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
    check({tag, "_res_value"},   bus.res_value,   0);
    check({tag, "_res_index"},   bus.res_index,   0);
    check({tag, "_res_frame"},   bus.res_frame,   0);
  endtask

  task automatic set_frame(input int k, input int v, input int idx, input int lat);
    f_val[k] = v;
    f_idx[k] = idx;
    f_lat[k] = lat;
  endtask

  // Runs one scan over frames f_*[0..]. hold < 0 picks a random number of
  // res_ready=0 cycles in DONE. abort_at >= 0 pulls reset 4 cycles into the
  // wait for that frame and ends the scan there.
  task automatic exec_scan(input int nf, input int hold, input int abort_at);
    int  n, n_run, exp_v, exp_i, exp_f, gap;
    bit  exp_to, keep;

    // Reference: first frame seeds the peak, later ones replace it only when
    // strictly larger; a silent tree stops the scan at that frame.
    n      = (nf == 0) ? 1 : nf;
    n_run  = n;
    exp_v  = 0;
    exp_i  = 0;
    exp_f  = 0;
    exp_to = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!exp_to) begin
        if (f_lat[k] == 0) begin
          exp_to = 1'b1;
          n_run  = k + 1;
        end else if (k == 0 || f_val[k] > exp_v) begin
          exp_v = f_val[k];
          exp_i = f_idx[k];
          exp_f = k % 256;
        end
      end
    end

    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_frames = 8'(nf);
    #1;
    check("idle_busy", bus.busy, 0);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.num_frames = 8'($urandom);
    #1;
    check("scan_busy",        bus.busy,        1);
    check("scan_to_cleared",  bus.timeout_err, 0);
    check("scan_val_cleared", bus.res_value,   0);

    for (int k = 0; k < n_run; k++) begin
      gap  = $urandom_range(0, 2);
      keep = 1'($urandom_range(0, 1));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.frame_valid  = 1'b0;
        bus.tree_max_dav = 1'b0;
        #1;
        check("gap_tree_dav", bus.tree_dav, 0);
      end
      @(negedge clk);
      bus.frame_valid  = 1'b1;
      bus.tree_max_dav = 1'b0;
      #1;
      check("launch_ready", bus.frame_ready, 1);
      check("launch_dav",   bus.tree_dav,    1);

      if (f_lat[k] == 0) begin
        for (int j = 1; j <= TIMEOUT; j++) begin
          @(negedge clk);
          bus.frame_valid    = keep;
          bus.tree_max_dav   = 1'b0;
          bus.tree_max_value = 16'($urandom);
          #1;
          check("to_wait_dav_low", bus.tree_dav, 0);
          if (j == TIMEOUT - 1) check("timeout_early", bus.timeout_err, 0);
          if (j == TIMEOUT)     check("timeout_flag",  bus.timeout_err, 1);
          if (j == TIMEOUT)     check("timeout_valid", bus.res_valid,   1);
        end
      end else begin
        for (int j = 1; j <= f_lat[k]; j++) begin
          @(negedge clk);
          bus.frame_valid  = keep;
          bus.tree_max_dav = (j == f_lat[k]);
          if (j == f_lat[k]) begin
            bus.tree_max_value = 16'(f_val[k]);
            bus.tree_max_index = IDX_W'(f_idx[k]);
          end else begin
            bus.tree_max_value = 16'($urandom);
            bus.tree_max_index = IDX_W'($urandom);
          end
          #1;
          check("wait_ready_low", bus.frame_ready, 0);
          check("wait_dav_low",   bus.tree_dav,    0);
          if (k == abort_at && j == 4) begin
            #2;
            rst = 1'b0;
            #1;
            check_cleared("rst_mid");
            bus.frame_valid = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            bus.tree_max_dav   = 1'b1;
            bus.tree_max_value = 16'hffff;
            bus.tree_max_index = '1;
            @(negedge clk);
            bus.tree_max_dav = 1'b0;
            #1;
            check_cleared("late_result");
            return;
          end
        end
      end
    end

    if (!exp_to) begin
      @(negedge clk);
      bus.tree_max_dav = 1'b0;
      #1;
    end

    if (hold < 0) hold = $urandom_range(0, 3);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        bus.start          = 1'($urandom_range(0, 1));
        bus.num_frames     = 8'($urandom);
        bus.frame_valid    = 1'($urandom_range(0, 1));
        bus.tree_max_dav   = 1'($urandom_range(0, 1));
        bus.tree_max_value = 16'hffff;
        bus.tree_max_index = IDX_W'($urandom);
        bus.res_ready      = 1'b0;
        #1;
      end
      check("done_valid",   bus.res_valid,   1);
      check("done_busy",    bus.busy,        1);
      check("done_value",   bus.res_value,   exp_v);
      check("done_index",   bus.res_index,   exp_i);
      check("done_frame",   bus.res_frame,   exp_f);
      check("done_timeout", bus.timeout_err, 32'(exp_to));
      check("done_ready",   bus.frame_ready, 0);
      check("done_dav",     bus.tree_dav,    0);
    end

    @(negedge clk);
    bus.res_ready    = 1'b1;
    bus.start        = 1'($urandom_range(0, 1));
    bus.tree_max_dav = 1'b0;
    #1;
    check("ack_cycle_valid", bus.res_valid, 1);
    @(negedge clk);
    bus.res_ready   = 1'b0;
    bus.start       = 1'b0;
    bus.frame_valid = 1'b0;
    #1;
    check("after_ack_busy",  bus.busy,      0);
    check("after_ack_valid", bus.res_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int nf, n;
    bus.start          = 1'b0;
    bus.num_frames     = 8'd0;
    bus.frame_valid    = 1'b0;
    bus.tree_max_value = 16'd0;
    bus.tree_max_index = '0;
    bus.tree_max_dav   = 1'b0;
    bus.res_ready      = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b1;

    // Three frames, peak in the middle; long DONE hold with ignored starts.
    set_frame(0, 100, 4, 32);
    set_frame(1, 300, 9, 32);
    set_frame(2, 200, 1, 32);
    exec_scan(3, 10, -1);

    // Equal maxima keep the earlier frame.
    set_frame(0, 500, 2, 5);
    set_frame(1, 500, 7, 3);
    exec_scan(2, -1, -1);

    // Tree never answers.
    set_frame(0, 0, 0, 0);
    exec_scan(1, -1, -1);

    // Zero values: the first frame still seeds the peak.
    set_frame(0, 0, 3, 2);
    set_frame(1, 0, 5, 1);
    exec_scan(2, -1, -1);

    // Timeout on a later frame keeps the earlier peak.
    set_frame(0, 700, 1, 10);
    set_frame(1, 0, 0, 0);
    exec_scan(2, -1, -1);

    // Latest allowed result latency.
    set_frame(0, 42, 30, TIMEOUT - 1);
    exec_scan(1, -1, -1);

    // num_frames = 0 runs exactly one frame.
    set_frame(0, 10, 6, 4);
    set_frame(1, 9000, 8, 4);
    exec_scan(0, -1, -1);

    // Reset in the wait for the third frame, then a normal scan.
    set_frame(0, 900, 6, 5);
    set_frame(1, 50, 2, 3);
    set_frame(2, 60, 3, 8);
    exec_scan(3, -1, 2);
    set_frame(0, 11, 12, 6);
    set_frame(1, 33, 13, 2);
    exec_scan(2, -1, -1);

    // Random scans.
    for (int s = 0; s < 20; s++) begin
      nf = $urandom_range(0, 6);
      n  = (nf == 0) ? 1 : nf;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 15) == 0) begin
          set_frame(k, 0, 0, 0);
        end else if ($urandom_range(0, 3) == 0) begin
          set_frame(k, int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)),
                    int'($urandom_range(1, TIMEOUT - 1)));
        end else begin
          set_frame(k, int'($urandom_range(0, 5)) * 100, int'($urandom_range(0, 31)),
                    int'($urandom_range(1, 12)));
        end
      end
      exec_scan(nf, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
